// File: rtl/uart_rx.sv
// Oversampled 8-data-bit UART receiver with one parity bit and one stop bit.
// Bits are sampled at their midpoint, and a frame is only started by a fresh falling edge on the line.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       baud_clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       parity_bit,
   output logic       valid,
   output logic       receiving,
   output logic       parity_err,
   output logic       framing_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    idx, idx_next;
   logic [7:0]    shreg, shreg_next;
   logic          par_rx, par_rx_next;
   logic          rx_meta, rx_s, rx_d;
   logic [7:0]    dout_next;
   logic          parity_bit_next, valid_next, parity_err_next, framing_err_next;

   // The synchronizer resets to the idle-high level so reset never looks like a start edge.
   always_ff @(posedge baud_clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         par_rx      <= 1'b0;
         dout        <= '0;
         parity_bit  <= 1'b0;
         valid       <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         idx         <= idx_next;
         shreg       <= shreg_next;
         par_rx      <= par_rx_next;
         dout        <= dout_next;
         parity_bit  <= parity_bit_next;
         valid       <= valid_next;
         parity_err  <= parity_err_next;
         framing_err <= framing_err_next;
      end
   end

   assign receiving = (state != IDLE);

   always_comb begin
      state_next       = state;
      cnt_next         = cnt + 1'b1;
      idx_next         = idx;
      shreg_next       = shreg;
      par_rx_next      = par_rx;
      dout_next        = dout;
      parity_bit_next  = parity_bit;
      valid_next       = 1'b0;
      parity_err_next  = parity_err;
      framing_err_next = framing_err;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (rx_d && !rx_s) state_next = START;
         end
         // A start bit that is high again at its midpoint was only a glitch.
         START: begin
            if (cnt == CNT_MID) begin
               cnt_next   = '0;
               idx_next   = '0;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_next        = '0;
               shreg_next[idx] = rx_s;
               if (idx == 3'd7) state_next = PARITY;
               else             idx_next   = idx + 3'd1;
            end
         end
         PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_next    = '0;
               par_rx_next = rx_s;
               state_next  = STOP;
            end
         end
         // Results are published only here, so they stay put between frames.
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_next         = '0;
               dout_next        = shreg;
               parity_bit_next  = par_rx;
               parity_err_next  = (^shreg) ^ par_rx ^ PARITY_ODD;
               framing_err_next = !rx_s;
               valid_next       = 1'b1;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed testbench for uart_rx.
// Every expected byte and flag comes from a frame-level model built from the bytes the bench transmits.
module tb_uart_rx;

   localparam int OS = 16;
   localparam bit PODD = 1'b0;
   localparam int LAT = (21 * OS) / 2 + 3;

   logic       baud_clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       parity_bit, valid, receiving, parity_err, framing_err;

   int total = 0;
   int bad = 0;
   int tick = 0;
   int vcount = 0;
   int double_valid = 0;
   int hold_bad = 0;

   logic [7:0] got_d[$];
   logic       got_pe[$], got_fe[$], got_par[$];
   int         got_lat[$];
   int         starts[$];

   logic [7:0] exp_d[$];
   logic       exp_pe[$], exp_fe[$], exp_par[$];

   uart_rx #(.OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
      .baud_clk(baud_clk), .reset(reset), .rx(rx), .dout(dout), .parity_bit(parity_bit),
      .valid(valid), .receiving(receiving), .parity_err(parity_err), .framing_err(framing_err)
   );

   always #5 baud_clk = ~baud_clk;

   always @(posedge baud_clk) tick++;

   // Record every valid pulse, plus any pulse longer than a cycle or any output change outside valid.
   logic        prev_valid = 1'b0;
   logic        prev_reset = 1'b1;
   logic [10:0] last_out = '0;
   always @(negedge baud_clk) begin
      if (valid) begin
         vcount++;
         got_d.push_back(dout);
         got_pe.push_back(parity_err);
         got_fe.push_back(framing_err);
         got_par.push_back(parity_bit);
         if (starts.size() > 0) got_lat.push_back(tick - starts.pop_front());
         else got_lat.push_back(-1);
         if (prev_valid) double_valid++;
      end else if (!prev_reset && !reset && {dout, parity_bit, parity_err, framing_err} !== last_out) begin
         hold_bad++;
      end
      prev_valid = valid;
      prev_reset = reset;
      last_out   = {dout, parity_bit, parity_err, framing_err};
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tickWait(input int n);
      repeat (n) begin
         @(posedge baud_clk);
         #1;
      end
   endtask

   task automatic driveBit(input logic b);
      rx = b;
      tickWait(OS);
   endtask

   // Transmit one frame and queue what a correct receiver must report for it.
   task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stopb);
      starts.push_back(tick);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(d[i]);
      driveBit(par);
      exp_d.push_back(d);
      exp_par.push_back(par);
      exp_pe.push_back((^d) ^ par ^ PODD);
      exp_fe.push_back(!stopb);
      driveBit(stopb);
   endtask

   task automatic waitFrames(input int n);
      int budget;
      budget = 4 * OS;
      while (vcount < n && budget > 0) begin
         tickWait(1);
         budget--;
      end
      checkOutput("valid_count", vcount, n);
   endtask

   // Compare the oldest received frame with the oldest expected one.
   task automatic checkFrame(input string tag);
      total++;
      if (got_d.size() == 0 || exp_d.size() == 0) begin
         bad++;
         $error("[TB] FAIL %s observed=no_frame expected=frame (got=%0d exp=%0d)", tag, got_d.size(), exp_d.size());
      end else begin
         int lat;
         logic [7:0] d, ed;
         d  = got_d.pop_front();
         ed = exp_d.pop_front();
         assert (d === ed) else begin
            bad++;
            $error("[TB] FAIL %s_dout observed=%0h expected=%0h", tag, d, ed);
         end
         checkOutput({tag, "_parity_err"}, got_pe.pop_front(), exp_pe.pop_front());
         checkOutput({tag, "_framing_err"}, got_fe.pop_front(), exp_fe.pop_front());
         checkOutput({tag, "_parity_bit"}, got_par.pop_front(), exp_par.pop_front());
         lat = got_lat.pop_front();
         checkOutput({tag, "_latency_ok"}, (lat >= LAT - 1 && lat <= LAT + 1), 1);
      end
   endtask

   initial begin
      int frames;
      logic [7:0] d, saved;
      logic p;
      frames = 0;

      $display("[TB] reset");
      reset = 1'b1;
      rx = 1'b1;
      tickWait(3);
      reset = 1'b0;
      tickWait(2);
      checkOutput("rst_dout", dout, 0);
      checkOutput("rst_valid", valid, 0);
      checkOutput("rst_receiving", receiving, 0);
      checkOutput("rst_parity_err", parity_err, 0);
      checkOutput("rst_framing_err", framing_err, 0);
      checkOutput("rst_parity_bit", parity_bit, 0);

      $display("[TB] basic frames");
      applyStimulus(8'hA5, 1'b0, 1'b1);
      frames++;
      tickWait(OS);
      waitFrames(frames);
      checkFrame("a5");
      applyStimulus(8'h3C, 1'b1, 1'b1);
      frames++;
      waitFrames(frames);
      checkFrame("3c_bad_parity");
      applyStimulus(8'h01, 1'b1, 1'b1);
      frames++;
      waitFrames(frames);
      checkFrame("01_good_parity");
      tickWait(2 * OS);

      $display("[TB] framing error and break");
      applyStimulus(8'h55, 1'b0, 1'b0);
      frames++;
      rx = 1'b0;
      tickWait(40 * OS);
      checkOutput("break_valid_count", vcount, frames);
      checkFrame("55_framing");
      checkOutput("break_receiving", receiving, 0);
      rx = 1'b1;
      tickWait(2 * OS);
      checkOutput("break_no_extra", vcount, frames);
      d = 8'hC3;
      applyStimulus(d, ^d, 1'b1);
      frames++;
      waitFrames(frames);
      checkFrame("after_break");
      tickWait(2 * OS);

      $display("[TB] glitch");
      saved = dout;
      rx = 1'b0;
      tickWait(4);
      checkOutput("glitch_receiving_hi", receiving, 1);
      rx = 1'b1;
      tickWait(2 * OS);
      checkOutput("glitch_receiving_lo", receiving, 0);
      checkOutput("glitch_no_valid", vcount, frames);
      checkOutput("glitch_dout_kept", dout, saved);

      $display("[TB] back-to-back and random frames");
      applyStimulus(8'h12, ^8'h12, 1'b1);
      applyStimulus(8'hFE, ^8'hFE, 1'b1);
      frames += 2;
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         applyStimulus(d, p, 1'b1);
         frames++;
      end
      waitFrames(frames);
      checkFrame("b2b_12");
      checkFrame("b2b_fe");
      for (int i = 0; i < 8; i++) checkFrame("random");
      tickWait(2 * OS);

      $display("[TB] reset mid-frame");
      d = 8'h77;
      rx = 1'b0;
      tickWait(OS);
      for (int i = 0; i < 4; i++) driveBit(d[i]);
      rx = d[4];
      tickWait(OS / 2);
      reset = 1'b1;
      tickWait(1);
      reset = 1'b0;
      checkOutput("midrst_receiving", receiving, 0);
      checkOutput("midrst_dout", dout, 0);
      rx = 1'b1;
      tickWait(12 * OS);
      checkOutput("midrst_no_valid", vcount, frames);
      applyStimulus(8'h88, ^8'h88, 1'b1);
      frames++;
      waitFrames(frames);
      checkFrame("88_after_reset");
      tickWait(2 * OS);

      checkOutput("final_valid_count", vcount, frames);
      checkOutput("single_cycle_valid", double_valid, 0);
      checkOutput("outputs_held_between_valids", hold_bad, 0);
      checkOutput("no_unexpected_frames", got_d.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
